// File: rtl/mem_bus_adapter.sv
// mem_bus_adapter: turns 32-bit pipeline loads/stores into one or more
// beats on a narrower (or equal) external bus of BUS_W bits.
// Optional feature macro: MEM_BUS_ADAPTER_MISALIGN_EN
//   defined   -> misaligned accesses are split across as many beats as needed
//   undefined -> misaligned accesses (addr mod 4 != 0) return resp_err=1
//                without touching the bus
module mem_bus_adapter #(
    parameter int BUS_W  = 16,
    parameter int ADDR_W = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 req_ready,
    output logic                 stall,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic [ADDR_W-1:0]    bus_addr,
    output logic                 bus_read,
    output logic                 bus_write,
    output logic [BUS_W-1:0]     bus_wdata,
    output logic [BUS_W/8-1:0]   bus_be,
    input  logic                 bus_busy,
    input  logic [BUS_W-1:0]     bus_rdata
);

    localparam int         L     = BUS_W / 8;
    localparam int         SH    = $clog2(L);
    localparam logic [1:0] OMASK = 2'(L - 1);

    typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;

    state_t              r_state;
    logic [1:0]          r_off;
    logic [1:0]          r_idx;
    logic [1:0]          r_nlast;
    logic                r_write;
    logic [31:0]         r_wdata;
    logic [31:0]         r_acc;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic                r_bus_read;
    logic                r_bus_write;
    logic [BUS_W-1:0]    r_bus_wdata;
    logic [L-1:0]        r_bus_be;
    logic                r_resp_valid;
    logic                r_resp_err;
    logic [31:0]         r_resp_rdata;

    logic [1:0]          w_off;
    logic [1:0]          w_nlast;
    logic [1:0]          w_idx_nxt;
    logic [ADDR_W-1:0]   w_base;
    logic [31:0]         w_merged;
    logic                w_err;

    // Lanes of beat idx that carry bytes of the 4-byte access starting at lane off.
    function automatic logic [L-1:0] f_be(input logic [1:0] off, input logic [1:0] idx);
        int k;
        f_be = '0;
        for (int j = 0; j < L; j++) begin
            k = int'(idx) * L + j - int'(off);
            if (k >= 0 && k < 4) f_be[j] = 1'b1;
        end
    endfunction

    // Store data of beat idx with each byte placed in its lane; idle lanes are 0.
    function automatic logic [BUS_W-1:0] f_wdata(input logic [1:0] off, input logic [1:0] idx,
                                                 input logic [31:0] wd);
        int         k;
        logic [1:0] kb;
        f_wdata = '0;
        for (int j = 0; j < L; j++) begin
            k  = int'(idx) * L + j - int'(off);
            kb = 2'(k);
            if (k >= 0 && k < 4) f_wdata[8*j +: 8] = wd[8*kb +: 8];
        end
    endfunction

    // Load data accumulated so far with the enabled lanes of this beat merged in.
    function automatic logic [31:0] f_merge(input logic [1:0] off, input logic [1:0] idx,
                                            input logic [31:0] acc, input logic [BUS_W-1:0] rd);
        int         k;
        logic [1:0] kb;
        f_merge = acc;
        for (int j = 0; j < L; j++) begin
            k  = int'(idx) * L + j - int'(off);
            kb = 2'(k);
            if (k >= 0 && k < 4) f_merge[8*kb +: 8] = rd[8*j +: 8];
        end
    endfunction

    // Lane offset, last beat index (= ceil((off+4)/L) - 1) and first bus word.
    assign w_off     = req_addr[1:0] & OMASK;
    assign w_nlast   = 2'((int'(w_off) + 3) / L);
    assign w_base    = req_addr >> SH;
    assign w_idx_nxt = r_idx + 2'd1;
    assign w_merged  = f_merge(r_off, r_idx, r_acc, bus_rdata);

`ifdef MEM_BUS_ADAPTER_MISALIGN_EN
    assign w_err = 1'b0;
`else
    assign w_err = |req_addr[1:0];
`endif

    // Sequencer: accept, walk the beats, then emit a single-cycle response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_off        <= '0;
            r_idx        <= '0;
            r_nlast      <= '0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_acc        <= '0;
            r_bus_addr   <= '0;
            r_bus_read   <= 1'b0;
            r_bus_write  <= 1'b0;
            r_bus_wdata  <= '0;
            r_bus_be     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_wdata <= req_wdata;
                        r_off   <= w_off;
                        r_nlast <= w_nlast;
                        r_idx   <= 2'd0;
                        r_acc   <= '0;
                        if (w_err) begin
                            // Misaligned without splitting support: no bus traffic at all.
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state     <= BEAT;
                            r_bus_addr  <= w_base;
                            r_bus_read  <= ~req_write;
                            r_bus_write <= req_write;
                            r_bus_be    <= f_be(w_off, 2'd0);
                            r_bus_wdata <= req_write ? f_wdata(w_off, 2'd0, req_wdata) : '0;
                        end
                    end
                end
                BEAT: begin
                    // While the bus is busy every bus register simply holds.
                    if (!bus_busy) begin
                        r_acc <= w_merged;
                        if (r_idx == r_nlast) begin
                            r_state      <= RESP;
                            r_bus_read   <= 1'b0;
                            r_bus_write  <= 1'b0;
                            r_bus_be     <= '0;
                            r_bus_wdata  <= '0;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b0;
                            if (!r_write) r_resp_rdata <= w_merged;
                        end else begin
                            r_idx       <= w_idx_nxt;
                            r_bus_addr  <= r_bus_addr + ADDR_W'(1);
                            r_bus_be    <= f_be(r_off, w_idx_nxt);
                            r_bus_wdata <= r_write ? f_wdata(r_off, w_idx_nxt, r_wdata) : '0;
                        end
                    end
                end
                RESP: begin
                    r_state    <= IDLE;
                    r_resp_err <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign stall      = (r_state != IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign bus_addr   = r_bus_addr;
    assign bus_read   = r_bus_read;
    assign bus_write  = r_bus_write;
    assign bus_wdata  = r_bus_wdata;
    assign bus_be     = r_bus_be;

endmodule
